// File: rtl/bcd_disp_pkg.sv
// Shared 7-segment constants and nibble decoder for the BCD display scanner.
// Patterns are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the top level.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Non-decimal nibbles show a dash so upstream conversion faults are visible.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern decoder.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with frame-synchronous double buffering,
// leading-zero blanking and registered pin drivers.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 9,
  parameter int unsigned PRESCALE   = 50000,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_done
);

  localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned   IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam bit            GAP_EN    = (PRESCALE >= 2);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    tick, wrap;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] active_digits_q, active_digits_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nibble;
  logic                    cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   anode_on;
  logic [6:0]              dec_seg, seg_on;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic                    frame_done_q, frame_done_d;

  // frame_done is registered one cycle early so it is high during the wrap cycle itself.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    wrap    = tick && (idx_q == IDX_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    if (!tick) begin
      idx_d = idx_q;
    end else if (wrap) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IW'(1);
    end
    frame_done_d = (presc_d == PRESC_MAX) && (idx_d == IDX_MAX);
  end

  // The commit takes the old shadow, so a load on the wrap cycle waits one more frame.
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    active_digits_d = active_digits_q;
    active_dp_d     = active_dp_q;
    pending_d       = pending_q;
    if (wrap && pending_q) begin
      active_digits_d = shadow_digits_q;
      active_dp_d     = shadow_dp_q;
      pending_d       = 1'b0;
    end
    if (load) begin
      shadow_digits_d = digits;
      shadow_dp_d     = dp;
      pending_d       = 1'b1;
    end
  end

  always_comb begin : blank_mask
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seen     = seen | (active_digits_q[4*i +: 4] != 4'd0);
      blank[i] = BLANK_LZ && (i != 0) && !seen;
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    anode_on   = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        cur_nibble  = active_digits_q[4*i +: 4];
        cur_dp      = active_dp_q[i];
        cur_blank   = blank[i];
        anode_on[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // First cycle of each slot keeps the anode dark to hide the segment transition.
  always_comb begin
    seg_on   = cur_blank ? 7'h00 : dec_seg;
    anode_d  = {NUM_DIGITS{ACTIVE_LOW}} ^
               ((GAP_EN && (presc_q == '0)) ? {NUM_DIGITS{1'b0}} : anode_on);
    seg_d    = {7{ACTIVE_LOW}} ^ seg_on;
    seg_dp_d = ACTIVE_LOW ^ cur_dp;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q         <= '0;
      idx_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      active_digits_q <= '0;
      active_dp_q     <= '0;
      pending_q       <= 1'b0;
      anode_q         <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q           <= {7{ACTIVE_LOW}};
      seg_dp_q        <= ACTIVE_LOW;
      frame_done_q    <= 1'b0;
    end else begin
      presc_q         <= presc_d;
      idx_q           <= idx_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      active_digits_q <= active_digits_d;
      active_dp_q     <= active_dp_d;
      pending_q       <= pending_d;
      anode_q         <= anode_d;
      seg_q           <= seg_d;
      seg_dp_q        <= seg_dp_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: three instances (blanking, no blanking, PRESCALE=1)
// checked every cycle against a cycle-count model, plus directed literal expectations.
module tb_bcd_display_scanner;

  localparam int N = 9;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        load = 1'b0;
  logic [35:0] digits = '0;
  logic [8:0]  dp = '0;

  logic [8:0] an  [3];
  logic [6:0] sg  [3];
  logic       sdp [3];
  logic       fd  [3];
  logic       pd  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  bcd_display_scanner #(.NUM_DIGITS(9), .PRESCALE(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut0 (
    .Clk(Clk), .Reset(Reset), .load(load), .digits(digits), .dp(dp), .pending(pd[0]),
    .anode(an[0]), .seg(sg[0]), .seg_dp(sdp[0]), .frame_done(fd[0])
  );
  bcd_display_scanner #(.NUM_DIGITS(9), .PRESCALE(4), .BLANK_LZ(0), .ACTIVE_LOW(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .load(load), .digits(digits), .dp(dp), .pending(pd[1]),
    .anode(an[1]), .seg(sg[1]), .seg_dp(sdp[1]), .frame_done(fd[1])
  );
  bcd_display_scanner #(.NUM_DIGITS(9), .PRESCALE(1), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .load(load), .digits(digits), .dp(dp), .pending(pd[2]),
    .anode(an[2]), .seg(sg[2]), .seg_dp(sdp[2]), .frame_done(fd[2])
  );

  // Reference model: everything derives from the cycle count since reset.
  int         mp [3] = '{4, 4, 1};
  bit         mb [3] = '{1'b1, 1'b0, 1'b1};
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int         cyc   [3];
  logic [35:0] sh_d [3];
  logic [35:0] ac_d [3];
  logic [8:0] sh_p  [3];
  logic [8:0] ac_p  [3];
  logic       pend  [3];
  logic [8:0] e_an  [3];
  logic [6:0] e_seg [3];
  logic       e_dp  [3];
  logic       e_fd  [3];
  bit         started = 1'b0;

  task automatic model_step(input int k);
    int   p, slot, phase;
    bit   blank;
    logic [3:0] nib;
    p = mp[k];
    if (Reset) begin
      cyc[k]   = 0;
      sh_d[k]  = '0;
      sh_p[k]  = '0;
      ac_d[k]  = '0;
      ac_p[k]  = '0;
      pend[k]  = 1'b0;
      e_an[k]  = 9'h1FF;
      e_seg[k] = 7'h7F;
      e_dp[k]  = 1'b1;
      e_fd[k]  = 1'b0;
    end else begin
      slot  = (cyc[k] / p) % N;
      phase = cyc[k] % p;
      e_an[k] = (phase == 0 && p >= 2) ? 9'h1FF : ~(9'd1 << slot);
      nib   = ac_d[k][4*slot +: 4];
      blank = mb[k] && (slot > 0) && ((ac_d[k] >> (4*slot)) == 36'd0);
      e_seg[k] = blank ? 7'h7F : ~pat[nib];
      e_dp[k]  = ~ac_p[k][slot];
      if ((cyc[k] % (p*N)) == p*N - 1 && pend[k]) begin
        ac_d[k] = sh_d[k];
        ac_p[k] = sh_p[k];
        pend[k] = 1'b0;
      end
      if (load) begin
        sh_d[k] = digits;
        sh_p[k] = dp;
        pend[k] = 1'b1;
      end
      cyc[k]  = cyc[k] + 1;
      e_fd[k] = ((cyc[k] % (p*N)) == p*N - 1);
    end
  endtask

  task automatic chk(input string name, input int k, input logic [8:0] got,
                     input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", name, k, $time, got, want);
    end
  endtask

  always @(posedge Clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    if (Reset) started = 1'b1;
    #1;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("anode", k, an[k], e_an[k]);
        chk("seg", k, 9'(sg[k]), 9'(e_seg[k]));
        chk("seg_dp", k, 9'(sdp[k]), 9'(e_dp[k]));
        chk("frame_done", k, 9'(fd[k]), 9'(e_fd[k]));
        chk("pending", k, 9'(pd[k]), 9'(pend[k]));
      end
    end
  end

  // Directed-test helpers.
  logic [6:0] sc_seg [9];
  logic       sc_dp  [9];

  task automatic do_load(input logic [35:0] d, input logic [8:0] p);
    load = 1'b1;
    digits = d;
    dp = p;
    @(negedge Clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      seen = fd[k];
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_fd dut%0d: got no frame_done want pulse within 200 cycles", k);
    end
  endtask

  // Call at the negedge of a frame's first cycle; records each slot's drive over one frame.
  task automatic scan(input int k);
    for (int s = 0; s < N; s++) begin
      sc_seg[s] = 7'h55;
      sc_dp[s]  = 1'bx;
    end
    for (int c = 0; c < 4*N; c++) begin
      @(negedge Clk);
      for (int s = 0; s < N; s++) begin
        if (an[k][s] == 1'b0) begin
          sc_seg[s] = sg[k];
          sc_dp[s]  = sdp[k];
        end
      end
    end
  endtask

  function automatic logic [35:0] rand_digits();
    logic [63:0] r;
    logic [35:0] d;
    int nz;
    r  = {$urandom(), $urandom()};
    d  = r[35:0];
    nz = int'($urandom_range(0, 9));
    for (int i = 0; i < N; i++) if (i >= N - nz) d[4*i +: 4] = 4'h0;
    return d;
  endfunction

  initial begin
    int n, gaps;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // 1: 1234 with leading-zero blanking.
    do_load(36'h000001234, 9'h000);
    wait_fd(0);
    @(negedge Clk);
    scan(0);
    chk("t1_seg0", 0, 9'(sc_seg[0]), 9'h19);
    chk("t1_seg1", 0, 9'(sc_seg[1]), 9'h30);
    chk("t1_seg2", 0, 9'(sc_seg[2]), 9'h24);
    chk("t1_seg3", 0, 9'(sc_seg[3]), 9'h79);
    for (int s = 4; s < N; s++) chk($sformatf("t1_seg%0d", s), 0, 9'(sc_seg[s]), 9'h7F);

    // 2: all zeros, dp on digit 2 (blanked digit still shows its point).
    do_load(36'h0, 9'h004);
    wait_fd(0);
    @(negedge Clk);
    scan(0);
    chk("t2_seg0", 0, 9'(sc_seg[0]), 9'h40);
    chk("t2_seg2", 0, 9'(sc_seg[2]), 9'h7F);
    chk("t2_dp2", 0, 9'(sc_dp[2]), 9'h0);
    chk("t2_dp0", 0, 9'(sc_dp[0]), 9'h1);
    chk("t2_dp5", 0, 9'(sc_dp[5]), 9'h1);

    // 3: non-decimal nibble, with and without blanking.
    do_load(36'h00000000A, 9'h000);
    wait_fd(0);
    @(negedge Clk);
    scan(1);
    chk("t3_nb_seg0", 1, 9'(sc_seg[0]), 9'h3F);
    chk("t3_nb_seg1", 1, 9'(sc_seg[1]), 9'h40);
    chk("t3_nb_seg8", 1, 9'(sc_seg[8]), 9'h40);
    scan(0);
    chk("t3_bl_seg0", 0, 9'(sc_seg[0]), 9'h3F);
    chk("t3_bl_seg1", 0, 9'(sc_seg[1]), 9'h7F);

    // 4: last load in a frame wins; load on the wrap cycle waits one more frame.
    wait_fd(0);
    @(negedge Clk);
    do_load(36'h5, 9'h000);
    do_load(36'h7, 9'h000);
    wait_fd(0);
    do_load(36'h3, 9'h000);
    chk("t4_pend_hold", 0, 9'(pd[0]), 9'h1);
    scan(0);
    chk("t4_seg0_7", 0, 9'(sc_seg[0]), 9'h78);
    chk("t4_pend_clr", 0, 9'(pd[0]), 9'h0);
    scan(0);
    chk("t4_seg0_3", 0, 9'(sc_seg[0]), 9'h30);

    // 5: reset mid-frame with a pending load.
    do_load(36'h99, 9'h000);
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t5_anode", 0, an[0], 9'h1FF);
    chk("t5_seg", 0, 9'(sg[0]), 9'h7F);
    chk("t5_pend", 0, 9'(pd[0]), 9'h0);
    Reset = 1'b0;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      n++;
      if (fd[0]) break;
    end
    chk("t5_fd_clocks", 0, 9'(n), 9'd36);
    @(negedge Clk);
    scan(0);
    chk("t5_seg0", 0, 9'(sc_seg[0]), 9'h40);
    chk("t5_seg1", 0, 9'(sc_seg[1]), 9'h7F);

    // 6: PRESCALE=1 frame period and no anode gap.
    wait_fd(2);
    n = 0;
    gaps = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      n++;
      if (an[2] == 9'h1FF) gaps++;
      if (fd[2]) break;
    end
    chk("t6_period", 2, 9'(n), 9'd9);
    chk("t6_gaps", 2, 9'(gaps), 9'd0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      Reset  = ($urandom_range(0, 299) == 0);
      load   = !Reset && ($urandom_range(0, 5) == 0);
      digits = rand_digits();
      dp     = 9'($urandom() & $urandom());
      @(negedge Clk);
    end
    Reset = 1'b0;
    load  = 1'b0;
    repeat (5) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
